// File: rtl/pc_rd_merge_pkg.sv
// pc_rd_merge_pkg: shared types and widths for the pseudo-channel read merger
package pc_rd_merge_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PC_NB_DEF = 8;
  localparam int CHUNK_BEAT_DEF = 4;
  localparam int BEAT_W_DEF = 16;
  function automatic int clog2_min1(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int PC_W = clog2_min1(PC_NB_DEF);
  localparam int CHUNK_W = clog2_min1(CHUNK_BEAT_DEF);
  typedef struct packed {
    logic [BEAT_W_DEF-1:0] beat_nb;
    logic [PC_W-1:0]       pc_start;
  } cmd_t;
endpackage

// File: rtl/pc_rd_merge_lane.sv
// pc_rd_merge_lane: per-channel synchronous FIFO with registered full/empty
module pc_rd_merge_lane #(
  parameter int DEPTH = 4,
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         s_rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic push, pull;
  always_comb begin
    push = wr_vld && !full;
    pull = rd && !empty;
    cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pull);
  end
  always_ff @(posedge clk) begin
    if (s_rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pull);
      cnt <= cnt_n;
      full <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wr_data;
  assign rd_data = mem[rp];
endmodule

// File: rtl/pc_rd_merge.sv
// pc_rd_merge: reassembles a chunk-striped read stream from per-channel lanes
module pc_rd_merge import pc_rd_merge_pkg::*; #(
  parameter int PC_NB = 8,
  parameter int DATA_W = 256,
  parameter int CHUNK_BEAT = 4,
  parameter int LANE_DEPTH = 4,
  parameter int BEAT_W = 16,
  localparam int PW = clog2_min1(PC_NB)
) (
  input  logic                    clk,
  input  logic                    s_rst,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  input  logic [BEAT_W-1:0]       cmd_beat_nb,
  input  logic [PW-1:0]           cmd_pc_start,
  input  logic [PC_NB*DATA_W-1:0] in_pc_data,
  input  logic [PC_NB-1:0]        in_pc_vld,
  output logic [PC_NB-1:0]        in_pc_rdy,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    out_last,
  output logic                    cmd_done,
  output logic                    error
);
  localparam int CW = clog2_min1(CHUNK_BEAT);
  state_t state;
  logic [BEAT_W-1:0] rem;
  logic [PW-1:0] pc;
  logic [CW-1:0] chunk;
  logic [PC_NB-1:0] empty, full, rd;
  logic [DATA_W-1:0] lane_q [PC_NB];
  logic accept, pop, ok, chunk_end, done_zero;
  genvar i;
  generate
    for (i = 0; i < PC_NB; i++) begin : g_lane
      pc_rd_merge_lane #(.DEPTH(LANE_DEPTH), .W(DATA_W)) u_lane (
        .clk(clk), .s_rst(s_rst),
        .wr_vld(in_pc_vld[i]), .wr_data(in_pc_data[i*DATA_W +: DATA_W]), .full(full[i]),
        .rd(rd[i]), .rd_data(lane_q[i]), .empty(empty[i])
      );
      assign in_pc_rdy[i] = !full[i] && !s_rst;
      assign rd[i] = pop && pc == PW'(i);
    end
  endgenerate
  always_comb begin
    ok = {1'b0, cmd_pc_start} < (PW+1)'(PC_NB);
    accept = cmd_vld && cmd_rdy;
    pop = state == RUN && !empty[pc] && (!out_vld || out_rdy);
    chunk_end = chunk == CW'(CHUNK_BEAT-1);
  end
  assign cmd_rdy = state == IDLE && !s_rst;
  assign cmd_done = !s_rst && (done_zero || (out_vld && out_rdy && out_last));
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state <= IDLE;
      rem <= '0;
      pc <= '0;
      chunk <= '0;
      out_vld <= 1'b0;
      out_last <= 1'b0;
      done_zero <= 1'b0;
      error <= 1'b0;
    end else begin
      done_zero <= accept && cmd_beat_nb == '0;
      error <= accept && !ok;
      if (accept) begin
        rem <= cmd_beat_nb;
        pc <= ok ? cmd_pc_start : '0;
        chunk <= '0;
        state <= cmd_beat_nb == '0 ? IDLE : RUN;
      end
      if (pop) begin
        rem <= rem - 1'b1;
        chunk <= chunk_end ? '0 : chunk + 1'b1;
        if (chunk_end) pc <= pc == PW'(PC_NB-1) ? '0 : pc + 1'b1;
        if (rem == BEAT_W'(1)) state <= IDLE;
        out_vld <= 1'b1;
        out_last <= rem == BEAT_W'(1);
      end else if (out_rdy) begin
        out_vld <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk)
    if (pop) out_data <= lane_q[pc];
endmodule

// File: tb/tb_pc_rd_merge.sv
// tb_pc_rd_merge: directed tests with a lane-queue model of the striped read order
module tb_pc_rd_merge;
  localparam int N = 8;
  localparam int DW = 256;
  logic clk = 0, s_rst = 1;
  always #5 clk = ~clk;
  logic cmd_vld, cmd_rdy, out_vld, out_rdy, out_last, cmd_done, error;
  logic [15:0] cmd_beat_nb;
  logic [2:0] cmd_pc_start;
  logic [N*DW-1:0] in_pc_data;
  logic [N-1:0] in_pc_vld, in_pc_rdy;
  logic [DW-1:0] out_data;
  pc_rd_merge dut (
    .clk(clk), .s_rst(s_rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_beat_nb(cmd_beat_nb), .cmd_pc_start(cmd_pc_start),
    .in_pc_data(in_pc_data), .in_pc_vld(in_pc_vld), .in_pc_rdy(in_pc_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .cmd_done(cmd_done), .error(error)
  );
  logic c5_vld, c5_rdy, o5_vld, o5_rdy, o5_last, o5_done, err5;
  logic [15:0] c5_nb, o5_data;
  logic [2:0] c5_st;
  logic [79:0] d5;
  logic [4:0] v5, r5;
  pc_rd_merge #(.PC_NB(5), .DATA_W(16), .CHUNK_BEAT(2)) dut5 (
    .clk(clk), .s_rst(s_rst), .cmd_vld(c5_vld), .cmd_rdy(c5_rdy),
    .cmd_beat_nb(c5_nb), .cmd_pc_start(c5_st),
    .in_pc_data(d5), .in_pc_vld(v5), .in_pc_rdy(r5),
    .out_data(o5_data), .out_vld(o5_vld), .out_rdy(o5_rdy), .out_last(o5_last),
    .cmd_done(o5_done), .error(err5)
  );
  int n_vec = 0, n_fail = 0;
  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [255:0] tag(int l, int s);
    return {224'h0, 8'hA5, l[7:0], s[15:0]};
  endfunction
  logic [255:0] lq [N][$];
  int seq[$];
  int pend[N], ser[N];
  bit gaps = 0, rmode = 0;
  logic [255:0] hist[$];
  bit hlast[$];
  int done_cnt = 0, streak = 0, max_streak = 0;
  initial begin : feeder
    logic [N-1:0] acc;
    in_pc_vld = '0;
    in_pc_data = '0;
    out_rdy = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_pc_vld & in_pc_rdy;
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          lq[i].push_back(tag(i, ser[i]));
          ser[i]++;
          pend[i]--;
        end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        in_pc_vld[i] = pend[i] > 0 && ((in_pc_vld[i] && !acc[i]) || !gaps || $urandom_range(0, 2) == 0);
        in_pc_data[i*DW +: DW] = tag(i, ser[i]);
      end
      out_rdy = rmode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end
  logic [255:0] pd, x;
  bit pl, stall = 0;
  int e, l;
  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    streak = out_vld ? streak + 1 : 0;
    if (streak > max_streak) max_streak = streak;
    if (s_rst || !out_vld) stall = 0;
    else begin
      if (stall) begin
        chk("hold_data", out_data, pd);
        chk("hold_last", out_last, pl);
      end
      if (out_rdy) begin
        if (seq.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL extra_beat: got %h want none", out_data);
        end else begin
          e = seq.pop_front();
          l = e & 255;
          x = lq[l].size() > 0 ? lq[l].pop_front() : '1;
          chk("data", out_data, x);
          chk("last", out_last, e >> 8);
          chk("done", cmd_done, e >> 8);
          hist.push_back(out_data);
          hlast.push_back(out_last);
        end
      end
      stall = !out_rdy;
      pd = out_data;
      pl = out_last;
    end
  end
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(int nb, int st);
    int t = 0;
    while (!cmd_rdy && t < 100) begin
      step(1);
      t++;
    end
    if (!cmd_rdy) begin
      n_vec++;
      n_fail++;
      $display("FAIL cmd_rdy_timeout: got 0 want 1");
    end
    cmd_vld = 1;
    cmd_beat_nb = 16'(nb);
    cmd_pc_start = 3'(st);
    for (int k = 0; k < nb; k++) seq.push_back(((st + k / 4) % N) | (k == nb - 1 ? 256 : 0));
    step(1);
    cmd_vld = 0;
  endtask
  task automatic drain(int budget);
    int t = 0;
    while (seq.size() > 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (seq.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats left want 0", seq.size());
    end
    step(3);
  endtask
  int b, d0;
  initial begin
    cmd_vld = 0; cmd_beat_nb = 0; cmd_pc_start = 0;
    c5_vld = 0; c5_nb = 0; c5_st = 0; d5 = '0; v5 = '0; o5_rdy = 1;
    step(3);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_in_rdy", in_pc_rdy, 8'h00);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_error", error, 0);
    s_rst = 0;
    step(1);
    chk("idle_cmd_rdy", cmd_rdy, 1);
    chk("idle_in_rdy", in_pc_rdy, 8'hFF);
    // full 8-lane pass from lane 0
    for (int i = 0; i < N; i++) pend[i] = 4;
    step(8);
    chk("lanes_full", in_pc_rdy, 8'h00);
    d0 = done_cnt;
    max_streak = 0;
    issue(32, 0);
    drain(200);
    chk("t1_beat0", hist[0], tag(0, 0));
    chk("t1_beat4", hist[4], tag(1, 0));
    chk("t1_beat31", hist[31], tag(7, 3));
    chk("t1_last31", hlast[31], 1);
    chk("t1_last30", hlast[30], 0);
    chk("t1_streak", max_streak, 32);
    chk("t1_done_cnt", done_cnt - d0, 1);
    // wrap from lane 6, lane 1 left untouched
    pend[6] += 4; pend[7] += 4; pend[0] += 2; pend[1] += 2;
    step(8);
    issue(10, 6);
    drain(200);
    chk("t2_beat0", hist[32], tag(6, 4));
    chk("t2_beat4", hist[36], tag(7, 4));
    chk("t2_beat8", hist[40], tag(0, 4));
    chk("t2_beat9", hist[41], tag(0, 5));
    chk("t2_last", hlast[41], 1);
    issue(2, 1);
    drain(200);
    chk("t2_lane1_a", hist[42], tag(1, 4));
    chk("t2_lane1_b", hist[43], tag(1, 5));
    // random arrival and back-pressure
    gaps = 1; rmode = 1;
    d0 = done_cnt;
    for (int k = 0; k < 40; k++) pend[(3 + k / 4) % N]++;
    issue(40, 3);
    drain(4000);
    gaps = 0; rmode = 0;
    step(2);
    chk("t3_count", hist.size(), 84);
    chk("t3_done_cnt", done_cnt - d0, 1);
    // zero-length command
    d0 = done_cnt;
    issue(0, 2);
    chk("zero_done", cmd_done, 1);
    chk("zero_vld", out_vld, 0);
    step(1);
    chk("zero_done_end", cmd_done, 0);
    chk("zero_cmd_rdy", cmd_rdy, 1);
    step(3);
    chk("zero_no_vld", out_vld, 0);
    chk("zero_done_cnt", done_cnt - d0, 1);
    chk("no_error", error, 0);
    // illegal start channel on a 5-channel instance
    v5 = 5'b00001; d5[15:0] = 16'h00A0;
    step(1);
    d5[15:0] = 16'h00A1;
    step(1);
    v5 = '0;
    c5_vld = 1; c5_nb = 2; c5_st = 7;
    step(1);
    c5_vld = 0;
    chk("err_pulse", err5, 1);
    chk("err_vld0", o5_vld, 0);
    step(1);
    chk("err_pulse_end", err5, 0);
    chk("err_vld1", o5_vld, 1);
    chk("err_beat0", o5_data, 16'h00A0);
    chk("err_last0", o5_last, 0);
    step(1);
    chk("err_beat1", o5_data, 16'h00A1);
    chk("err_last1", o5_last, 1);
    chk("err_done", o5_done, 1);
    step(1);
    chk("err_vld_end", o5_vld, 0);
    // reset in the middle of a transfer
    for (int i = 0; i < 4; i++) pend[i] += 4;
    d0 = done_cnt;
    b = hist.size();
    issue(16, 0);
    fork
      wait (hist.size() == b + 5);
      repeat (300) @(posedge clk);
    join_any
    disable fork;
    chk("t5_five_beats", hist.size(), b + 5);
    s_rst = 1;
    step(1);
    chk("t5_rst_vld", out_vld, 0);
    chk("t5_rst_done", cmd_done, 0);
    chk("t5_rst_cmd_rdy", cmd_rdy, 0);
    seq.delete();
    for (int i = 0; i < N; i++) begin
      lq[i].delete();
      pend[i] = 0;
    end
    step(1);
    s_rst = 0;
    step(1);
    chk("t5_no_done", done_cnt - d0, 0);
    pend[2] = 4;
    step(8);
    b = hist.size();
    issue(4, 2);
    drain(200);
    chk("t5_fresh0", hist[b], tag(2, ser[2] - 4));
    chk("t5_fresh3", hist[b + 3], tag(2, ser[2] - 1));
    // beats parked while idle, then minimum latency
    pend[3] = 4;
    step(8);
    chk("t6_lane3_full", in_pc_rdy[3], 0);
    issue(4, 3);
    chk("t6_vld_acc1", out_vld, 0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("t6_b2b_vld", out_vld, 1);
      chk("t6_b2b_last", out_last, k == 3);
    end
    step(1);
    chk("t6_vld_end", out_vld, 0);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
